// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store sequencer: op and state
// encodings, request payload, data constants and the alignment helper.
package mem_access_unit_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANE_W = 2;

  localparam logic              VALID   = 1'b1;
  localparam logic              INVALID = 1'b0;
  localparam logic [DATA_W-1:0] ZERO    = '0;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LW  = 3'b010,
    OP_SB  = 3'b011,
    OP_LBU = 3'b100,
    OP_LHU = 3'b101,
    OP_SW  = 3'b110,
    OP_SH  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RMW_WR = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

  // Request fields captured on accept; only the byte lane of the address is
  // needed after the word address has been registered.
  typedef struct packed {
    op_e               op;
    logic [LANE_W-1:0] lane;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic logic is_load(input op_e op);
    logic res;
    res = !((op == OP_SB) || (op == OP_SH) || (op == OP_SW));
    return res;
  endfunction

  // Halfword ops need an even address, word ops a word-aligned one.
  function automatic logic is_misaligned(input op_e op, input logic [LANE_W-1:0] lane);
    logic res;
    res = INVALID;
    case (op)
      OP_LH, OP_LHU, OP_SH: res = lane[0];
      OP_LW, OP_SW:         res = (lane != 2'b00);
      default:              res = INVALID;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane steering between a memory word and the pipeline.
//   op           : access type
//   lane         : addr[1:0] of the access
//   word         : word read from memory
//   wdata        : store data from the pipeline
//   load_val_c   : selected byte/halfword/word, sign or zero extended
//   store_word_c : word with the addressed byte/halfword replaced by wdata
module mem_lane_unit
  import mem_access_unit_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  op_e               op,
  input  logic [LANE_W-1:0] lane,
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_val_c,
  output logic [DATA_W-1:0] store_word_c
);

  logic [1:0]  byte_pos;
  logic        half_pos;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // In big-endian mode lane 3-n is ~n; a halfword pair {a1,0},{a1,1} then
  // lands in the opposite half with its bytes already in value order.
  always_comb begin
    byte_pos     = BIG_ENDIAN ? ~lane : lane;
    half_pos     = BIG_ENDIAN ? ~lane[1] : lane[1];
    sel_byte     = word[{byte_pos, 3'b000} +: 8];
    sel_half     = word[{half_pos, 4'b0000} +: 16];
    load_val_c   = word;
    store_word_c = word;
    case (op)
      OP_LB:   load_val_c = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  load_val_c = {24'h000000, sel_byte};
      OP_LH:   load_val_c = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  load_val_c = {16'h0000, sel_half};
      OP_SB:   store_word_c[{byte_pos, 3'b000} +: 8] = wdata[7:0];
      OP_SH:   store_word_c[{half_pos, 4'b0000} +: 16] = wdata[15:0];
      OP_SW:   store_word_c = wdata;
      default: load_val_c = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the pipeline and a word-wide data memory.
// Adds sub-word loads with extension, sub-word stores by read-modify-write,
// alignment/range checking and a req/done handshake.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req/op/addr/wdata   : request, sampled only while idle
//   rdata               : load result, held until the next load completes
//   done, addr_err      : completion pulse and its error flag
//   busy                : high whenever a request is in flight
//   mem_ce/we/addr/wdata: data memory controls (all registered)
//   mem_rdata           : combinational memory read word
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              addr_err,
  output logic              busy,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned     ADDR_EXT_W = DATA_W + 1;
  localparam logic [DATA_W:0] MEM_BYTES  = ADDR_EXT_W'(MEM_WORDS) << 2;

  state_e            state_q, state_d;
  mem_req_t          req_q, req_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              addr_err_q, addr_err_d;
  logic              busy_q, busy_d;
  logic              mem_ce_q, mem_ce_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  op_e               op_in;
  logic              req_bad;
  logic [DATA_W-1:0] load_val_c;
  logic [DATA_W-1:0] store_word_c;

  assign op_in   = op_e'(op);
  assign req_bad = is_misaligned(op_in, addr[1:0]) ||
                   ({1'b0, addr} >= MEM_BYTES);

  // Lane steering works on the captured request against the live read word.
  mem_lane_unit #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_lane (
    .op           (req_q.op),
    .lane         (req_q.lane),
    .word         (mem_rdata),
    .wdata        (req_q.wdata),
    .load_val_c   (load_val_c),
    .store_word_c (store_word_c)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rdata_d     = rdata_q;
    done_d      = INVALID;
    addr_err_d  = INVALID;
    mem_ce_d    = INVALID;
    mem_we_d    = INVALID;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          req_d      = '{op: op_in, lane: addr[1:0], wdata: wdata};
          mem_addr_d = {addr[DATA_W-1:2], 2'b00};
          if (req_bad) begin
            state_d    = ST_RESP;
            done_d     = VALID;
            addr_err_d = VALID;
          end else begin
            state_d  = ST_ACCESS;
            mem_ce_d = VALID;
            if (op_in == OP_SW) begin
              mem_we_d    = VALID;
              mem_wdata_d = wdata;
            end
          end
        end
      end

      ST_ACCESS: begin
        if (is_load(req_q.op)) begin
          rdata_d = load_val_c;
          state_d = ST_RESP;
          done_d  = VALID;
        end else if (req_q.op == OP_SW) begin
          state_d = ST_RESP;
          done_d  = VALID;
        end else begin
          // Old word is merged with the store data as it is captured.
          mem_wdata_d = store_word_c;
          mem_ce_d    = VALID;
          mem_we_d    = VALID;
          state_d     = ST_RMW_WR;
        end
      end

      ST_RMW_WR: begin
        state_d = ST_RESP;
        done_d  = VALID;
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops the memory strobes at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '{op: OP_LB, lane: 2'b00, wdata: ZERO};
      rdata_q     <= ZERO;
      done_q      <= INVALID;
      addr_err_q  <= INVALID;
      busy_q      <= INVALID;
      mem_ce_q    <= INVALID;
      mem_we_q    <= INVALID;
      mem_addr_q  <= ZERO;
      mem_wdata_q <= ZERO;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      addr_err_q  <= addr_err_d;
      busy_q      <= busy_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign rdata     = rdata_q;
  assign done      = done_q;
  assign addr_err  = addr_err_q;
  assign busy      = busy_q;
  assign mem_ce    = mem_ce_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: one little-endian and one big-endian instance,
// each with its own word memory. Expected responses come from a byte-level
// reference model and are checked by a monitor as done pulses appear.
module tb_mem_access_unit;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] SB  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SW  = 3'b110;
  localparam logic [2:0] SH  = 3'b111;
  localparam logic [31:0] MEM_BYTES = 32'h0000_1000;

  typedef struct {
    int          k;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_n;

  logic        req_i       [2];
  logic [2:0]  op_i        [2];
  logic [31:0] addr_i      [2];
  logic [31:0] wdata_i     [2];
  logic [31:0] rdata_o     [2];
  logic        done_o      [2];
  logic        addr_err_o  [2];
  logic        busy_o      [2];
  logic        mem_ce_o    [2];
  logic        mem_we_o    [2];
  logic [31:0] mem_addr_o  [2];
  logic [31:0] mem_wdata_o [2];
  logic [31:0] mem_rdata_i [2];

  logic [31:0] env_mem [2][1024];
  logic [31:0] ref_mem [2][1024];
  logic [31:0] ref_rdata [2];

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   ce_cnt   [2];
  int   we_cnt   [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_access_unit #(
      .MEM_WORDS  (1024),
      .BIG_ENDIAN (g == 1)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_i[g]),
      .op        (op_i[g]),
      .addr      (addr_i[g]),
      .wdata     (wdata_i[g]),
      .rdata     (rdata_o[g]),
      .done      (done_o[g]),
      .addr_err  (addr_err_o[g]),
      .busy      (busy_o[g]),
      .mem_ce    (mem_ce_o[g]),
      .mem_we    (mem_we_o[g]),
      .mem_addr  (mem_addr_o[g]),
      .mem_wdata (mem_wdata_o[g]),
      .mem_rdata (mem_rdata_i[g])
    );
    assign mem_rdata_i[g] = env_mem[g][mem_addr_o[g][11:2]];
  end

  // Data memories: combinational read, word write on the clock edge.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (mem_ce_o[k] && mem_we_o[k]) env_mem[k][mem_addr_o[k][11:2]] <= mem_wdata_o[k];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Monitor: counts memory strobes and scores every done pulse.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (mem_ce_o[k]) ce_cnt[k]++;
      if (mem_we_o[k]) we_cnt[k]++;
      if (done_o[k]) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: inst %0d pulsed done with nothing outstanding", k);
        end else begin
          e = exp_q.pop_front();
          chk("done_inst", 32'(k), 32'(e.k));
          chk("rdata", rdata_o[k], e.rdata);
          chk("addr_err", 32'(addr_err_o[k]), 32'(e.err));
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // ---------------- reference model: byte-addressed memory ----------------
  function automatic int unsigned op_size(input logic [2:0] o);
    int unsigned n;
    case (o)
      LB, LBU, SB: n = 1;
      LH, LHU, SH: n = 2;
      default:     n = 4;
    endcase
    return n;
  endfunction

  function automatic int unsigned lane_shift(input int k, input logic [31:0] a);
    int unsigned l;
    l = int'(a[1:0]);
    return (k == 1) ? 8 * (3 - l) : 8 * l;
  endfunction

  function automatic logic [7:0] ref_rd_byte(input int k, input logic [31:0] a);
    logic [31:0] w;
    w = ref_mem[k][a[11:2]];
    return 8'(w >> lane_shift(k, a));
  endfunction

  task automatic ref_wr_byte(input int k, input logic [31:0] a, input logic [7:0] b);
    logic [31:0] w;
    w = ref_mem[k][a[11:2]];
    w[lane_shift(k, a) +: 8] = b;
    ref_mem[k][a[11:2]] = w;
  endtask

  task automatic model_txn(input int k, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] wd, output logic err, output int lat,
                           output int nce, output int nwe);
    int unsigned n;
    logic        store, sgn;
    logic [31:0] val;
    logic [7:0]  b;
    n     = op_size(o);
    store = (o == SB) || (o == SH) || (o == SW);
    sgn   = (o == LB) || (o == LH);
    err   = (a >= MEM_BYTES) || ((a % n) != 0);
    if (err) begin
      lat = 1; nce = 0; nwe = 0;
    end else if (store) begin
      for (int unsigned i = 0; i < n; i++) begin
        b = (k == 1) ? 8'(wd >> (8 * (n - 1 - i))) : 8'(wd >> (8 * i));
        ref_wr_byte(k, a + i, b);
      end
      lat = (n == 4) ? 2 : 3;
      nce = (n == 4) ? 1 : 2;
      nwe = 1;
    end else begin
      val = '0;
      for (int unsigned i = 0; i < n; i++) begin
        b = ref_rd_byte(k, a + i);
        if (k == 1) val = (val << 8) | 32'(b);
        else        val = val | (32'(b) << (8 * i));
      end
      if (sgn && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
      ref_rdata[k] = val;
      lat = 2; nce = 1; nwe = 0;
    end
  endtask

  // Issue one request on instance k, wait for it to finish, check side effects.
  task automatic do_txn(input int k, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] wd);
    logic err;
    int   lat, nce, nwe, ce0, we0, n;
    exp_t e;
    @(negedge clk);
    model_txn(k, o, a, wd, err, lat, nce, nwe);
    e.k = k; e.rdata = ref_rdata[k]; e.err = err; e.cyc = cyc + lat;
    exp_q.push_back(e);
    ce0 = ce_cnt[k];
    we0 = we_cnt[k];
    req_i[k] = 1'b1; op_i[k] = o; addr_i[k] = a; wdata_i[k] = wd;
    @(posedge clk);
    #1;
    req_i[k] = 1'b0;
    n = 0;
    while (busy_o[k] && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("txn_returns_idle", 32'(busy_o[k]), 32'd0);
    chk("ce_cycles", 32'(ce_cnt[k] - ce0), 32'(nce));
    chk("we_cycles", 32'(we_cnt[k] - we0), 32'(nwe));
    if (a < MEM_BYTES) chk("mem_word", env_mem[k][a[11:2]], ref_mem[k][a[11:2]]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  o;
    logic [31:0] a;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_i[k] = 1'b0; op_i[k] = 3'b000; addr_i[k] = '0; wdata_i[k] = '0;
      ref_rdata[k] = '0; ce_cnt[k] = 0; we_cnt[k] = 0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_rdata", rdata_o[k], 32'h0);
      chk("rst_done", 32'(done_o[k]), 32'h0);
      chk("rst_addr_err", 32'(addr_err_o[k]), 32'h0);
      chk("rst_busy", 32'(busy_o[k]), 32'h0);
      chk("rst_mem_ce", 32'(mem_ce_o[k]), 32'h0);
      chk("rst_mem_we", 32'(mem_we_o[k]), 32'h0);
      chk("rst_mem_addr", mem_addr_o[k], 32'h0);
      chk("rst_mem_wdata", mem_wdata_o[k], 32'h0);
    end
    rst_n = 1'b1;

    // Give the first 16 words of each memory known contents.
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 16; w++) do_txn(k, SW, 32'(w * 4), $urandom());

    // Little-endian directed cases.
    do_txn(0, SW, 32'h8, 32'h1234_5678);
    do_txn(0, LW, 32'h8, 32'h0);
    chk("lw_word8", rdata_o[0], 32'h1234_5678);
    do_txn(0, SB, 32'h9, 32'h0000_00AB);
    chk("sb_word8", env_mem[0][2], 32'h1234_AB78);
    do_txn(0, SW, 32'h10, 32'h80FF_7F01);
    do_txn(0, LB, 32'h12, 32'h0);
    chk("lb_0x12", rdata_o[0], 32'hFFFF_FFFF);
    do_txn(0, LBU, 32'h12, 32'h0);
    chk("lbu_0x12", rdata_o[0], 32'h0000_00FF);
    do_txn(0, LH, 32'h12, 32'h0);
    chk("lh_0x12", rdata_o[0], 32'hFFFF_80FF);
    do_txn(0, LHU, 32'h10, 32'h0);
    chk("lhu_0x10", rdata_o[0], 32'h0000_7F01);
    do_txn(0, LW, 32'h6, 32'h0);
    do_txn(0, SH, 32'h3, 32'hDEAD_BEEF);
    do_txn(0, SW, 32'h1000, 32'hCAFE_F00D);
    chk("rdata_held_after_errors", rdata_o[0], 32'h0000_7F01);

    // Big-endian directed cases.
    do_txn(1, SW, 32'h0, 32'h1122_3344);
    do_txn(1, LBU, 32'h0, 32'h0);
    chk("be_lbu_0x0", rdata_o[1], 32'h0000_0011);
    do_txn(1, SH, 32'h2, 32'h0000_BEEF);
    chk("be_sh_word0", env_mem[1][0], 32'h1122_BEEF);

    // Reset during the write cycle of a read-modify-write.
    @(negedge clk);
    req_i[0] = 1'b1; op_i[0] = SB; addr_i[0] = 32'h9; wdata_i[0] = 32'h0000_00CD;
    @(posedge clk);
    #1;
    req_i[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("rmw_we_before_reset", 32'(mem_we_o[0]), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("reset_drops_we", 32'(mem_we_o[0]), 32'h0);
    chk("reset_drops_ce", 32'(mem_ce_o[0]), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ref_rdata[0] = '0;
    ref_rdata[1] = '0;
    chk("abort_word_unchanged", env_mem[0][2], 32'h1234_AB78);
    chk("abort_busy", 32'(busy_o[0]), 32'h0);
    chk("abort_rdata_reset", rdata_o[0], 32'h0);
    do_txn(0, LW, 32'h8, 32'h0);
    chk("lw_after_abort", rdata_o[0], 32'h1234_AB78);

    // Randomized traffic over both instances.
    for (int t = 0; t < 400; t++) begin
      o = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = MEM_BYTES + 32'($urandom_range(0, 4095));
      else                           a = 32'($urandom_range(0, 63));
      do_txn(t % 2, o, a, $urandom());
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer for the MEM stage; sits between the pipeline and the word-wide data memory (1024 x 32 words).
- Data memory interface: combinational read, word write on posedge clk, word-indexed by addr[11:2], no byte enables.
- This block adds:
  - byte/halfword loads with sign/zero extension;
  - byte/halfword stores via read-modify-write;
  - alignment and range checking;
  - a req/done handshake.

Parameters:
- MEM_WORDS, 1024: data memory depth in words; byte addresses >= MEM_WORDS*4 are out of range.
- BIG_ENDIAN, 0: 0 means byte lane = addr[1:0]; 1 means byte lane = 3 - addr[1:0].

Ports:
- clk  in  1  clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- req  in  1  request strobe; sampled only in IDLE
- op  in  3  000 LB, 001 LH, 010 LW, 011 SB, 100 LBU, 101 LHU, 110 SW, 111 SH
- addr  in  32  byte address
- wdata  in  32  store data (SB uses [7:0], SH uses [15:0])
- rdata  out  32  load result, extended; valid in the done cycle and held until the next done
- done  out  1  one-cycle completion pulse
- addr_err  out  1  valid with done; 1 means misaligned or out of range, no memory access made
- busy  out  1  high whenever state != IDLE
- mem_ce  out  1  data memory chip enable
- mem_we  out  1  data memory write enable
- mem_addr  out  32  data memory address, {addr[31:2],2'b00}
- mem_wdata  out  32  data memory write word
- mem_rdata  in  32  data memory read word (combinational)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE;
  - rdata, mem_addr, mem_wdata = 0;
  - done, addr_err, busy, mem_ce, mem_we = 0.
  - Reset asserted mid-operation drops mem_ce/mem_we immediately, so no partial write occurs. No done pulse is issued for an aborted request.
- mem_* outputs decode from state and captured request registers only. There is no combinational path from req/op/addr/wdata.
- States: IDLE, ACCESS, RMW_WR, RESP.
- IDLE:
  - req=1 captures op/addr/wdata.
  - Error check: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; addr >= MEM_WORDS*4.
  - Error -> RESP with err flag set. Otherwise -> ACCESS.
- ACCESS (one cycle, mem_ce=1):
  - Loads, mem_we=0: sample mem_rdata at the end of the cycle; extract lane; LB/LH sign-extend, LBU/LHU zero-extend; -> RESP.
  - SW, mem_we=1, mem_wdata=wdata: the word is written at the end of this cycle; -> RESP.
  - SB/SH, mem_we=0: latch mem_rdata as old word; -> RMW_WR.
- RMW_WR (mem_ce=1, mem_we=1):
  - mem_wdata = old word with the selected byte lane (SB) or halfword lanes (SH: lanes {addr[1],0} and {addr[1],1} before endian mapping) replaced by wdata; -> RESP.
- RESP:
  - done=1; addr_err=err flag; rdata updated for loads only (unchanged on stores and errors); -> IDLE.
- Latency, counting the req-accept edge as cycle 0; done is high in cycle:
  - error: 1
  - LW/LB/LH/LBU/LHU/SW: 2
  - SB/SH: 3
- Throughput: a new req is accepted in the cycle after done (IDLE again). req while busy is ignored, not queued.
- Simultaneous events: req held high continuously starts a new request on every IDLE cycle.
- mem_ce=0 in IDLE and RESP; mem_we is never 1 outside ACCESS(SW) and RMW_WR.

Decomposition:
- Shared def.v header gets: op encodings (LB..SH), state encodings, and the existing VALID/INVALID/ZERO constants.
- One natural sub-module, mem_lane_unit (combinational). Inputs: op, addr[1:0], word, wdata, BIG_ENDIAN. Outputs: extended load value and merged store word. It is reused by both ACCESS and RMW_WR.

Test Plan:
- SW addr=0x8 wdata=0x12345678, then LW addr=0x8 -> mem_we pulse 1 cycle at mem_addr=0x8; LW done at cycle 2 with rdata=0x12345678, addr_err=0.
- With word 0x8 = 0x12345678: SB addr=0x9 wdata=0xAB -> read cycle then write cycle; word becomes 0x1234AB78; done at cycle 3.
- Word 0x10 = 0x80FF7F01:
  - LB 0x12 -> 0xFFFFFFFF
  - LBU 0x12 -> 0x000000FF
  - LH 0x12 -> 0xFFFF80FF
  - LHU 0x10 -> 0x00007F01
- Misaligned/out-of-range:
  - LW 0x6, SH 0x3, SW 0x1000 (MEM_WORDS=1024) -> done at cycle 1 with addr_err=1.
  - mem_ce stays 0 throughout; memory and rdata unchanged.
- BIG_ENDIAN=1, word 0x0 = 0x11223344: LBU 0x0 -> 0x11; SH 0x2 wdata=0xBEEF -> word 0x1122BEEF.
- Assert rst_n=0 during RMW_WR of an SB:
  - mem_we falls immediately; target word unchanged; no done pulse.
  - After release: busy=0; the next LW completes normally.
